operand_packer: RTL and testbench
=================================

OPERAND_PACKER -- requirements
Module: operand_packer

Interface
REQ-001 SHALL have parameter NUM_OPERANDS, default 9: number of operand lanes per output vector (>=1).
REQ-002 SHALL have parameter DATA_WIDTH, default 8: width of each operand word.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port in_data, input, DATA_WIDTH: serial operand word.
REQ-006 SHALL have port in_valid, input, 1: in_data is valid this cycle.
REQ-007 SHALL have port in_last, input, 1: current word closes the vector early; sampled only on an accepted word.
REQ-008 SHALL have port in_ready, output, 1: packer accepts a word this cycle.
REQ-009 SHALL have port out_operands, output, [NUM_OPERANDS-1:0][DATA_WIDTH-1:0]: packed vector that feeds the adder-tree operands input.
REQ-010 SHALL have port out_count, output, $clog2(NUM_OPERANDS+1): number of real (non-pad) lanes in out_operands.
REQ-011 SHALL have port out_valid, output, 1: out_operands/out_count valid.
REQ-012 SHALL have port out_ready, input, 1: consumer takes the vector this cycle.

Function
REQ-013 SHALL accept a word when in_valid && in_ready at the clock edge; the k-th accepted word of a vector (k from 0) goes to lane k.
REQ-014 SHALL complete a vector on the accepted word that is lane NUM_OPERANDS-1 or that carries in_last=1, whichever comes first.
REQ-015 SHALL fill lanes beyond the last accepted word with zero; out_count equals the number of accepted words (1..NUM_OPERANDS).
REQ-016 SHALL implement two states: FILL (in_ready=1) and HOLD (in_ready=0); in_ready is a function of state only.
REQ-017 SHALL, when a vector completes in FILL and the output slot is free (out_valid=0, or out_valid && out_ready in the same cycle), load out_operands/out_count and set out_valid=1 on that edge: one-cycle latency from completing word to out_valid, no bubble.
REQ-018 SHALL, when a vector completes and the output slot is not free, retain it in the fill buffer and enter HOLD.
REQ-019 SHALL, in HOLD, transfer the fill buffer to the output on the edge where out_valid && out_ready, keep out_valid=1, and return to FILL.
REQ-020 SHALL clear out_valid on out_valid && out_ready when no completed vector is transferred on that edge.
REQ-021 SHALL keep out_operands and out_count stable while out_valid=1 && out_ready=0.
REQ-022 SHALL clear the fill buffer and lane counter to zero after each transfer.
REQ-023 SHALL ignore in_data/in_last when in_valid=0; gaps in in_valid SHALL not disturb a partial vector.
REQ-024 SHALL sustain one accepted word per cycle indefinitely when out_ready=1 and NUM_OPERANDS>=2.
REQ-025 SHALL, for NUM_OPERANDS=1, complete a vector on every accepted word.

Reset
REQ-026 SHALL, on a clock edge with rst_n=0, set state FILL, lane counter 0, fill buffer 0, out_operands 0, out_count 0, out_valid 0.
REQ-027 SHALL discard any partial or held vector on reset mid-operation; in_valid SHALL have no effect in a cycle where rst_n=0.
REQ-028 SHALL present in_ready=1 in the first cycle after rst_n returns high.

Verification
REQ-029 SHALL test: N=9, W=8, out_ready=1, in_data 0..8 back-to-back -> out_valid high one cycle after word 8, lanes[i]=i, out_count=9; downstream adder tree sum = 36.
REQ-030 SHALL test: words 5,6,7 with in_last on 7 -> lanes {5,6,7,0,0,0,0,0,0}, out_count=3; next vector starts at lane 0.
REQ-031 SHALL test: out_ready=0, 18 words offered -> vector 1 (0..8) held stable; after word 17 in_ready=0 (HOLD); one out_ready pulse -> vector 2 (9..17) valid on the next edge, in_ready=1.
REQ-032 SHALL test: rst_n=0 for one cycle after 4 words -> out_valid=0, out_count=0; next 9 words 20..28 form a fresh vector with lanes[0]=20.
REQ-033 SHALL test: in_valid toggling every other cycle over 9 words 1..9 -> single vector lanes[i]=i+1, out_count=9, no extra out_valid pulse.
REQ-034 SHALL test: out_ready held 1 with a continuous stream of 27 words -> three consecutive vectors, in_ready never deasserted.

Source files
------------

// File: rtl/operand_packer_if.sv
// operand_packer_if -- handshake bundle between a serial operand source,
// the operand packer and the downstream adder-tree consumer.
//   in_data/in_valid/in_last  : serial operand word stream into the packer
//   in_ready                  : packer can accept a word this cycle
//   out_operands/out_count    : packed vector and number of real lanes
//   out_valid/out_ready       : output vector handshake
// Modports: slave = packer side, master = source/consumer side.
interface operand_packer_if #(
  parameter int NUM_OPERANDS = 9,
  parameter int DATA_WIDTH   = 8
) ();
  localparam int CNT_W = $clog2(NUM_OPERANDS + 1);

  logic [DATA_WIDTH-1:0]                   in_data;
  logic                                    in_valid;
  logic                                    in_last;
  logic                                    in_ready;
  logic [NUM_OPERANDS-1:0][DATA_WIDTH-1:0] out_operands;
  logic [CNT_W-1:0]                        out_count;
  logic                                    out_valid;
  logic                                    out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_operands, out_count, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_operands, out_count, out_valid
  );
endinterface

// File: rtl/operand_packer.sv
// operand_packer -- collects serial operand words into a parallel vector of
// NUM_OPERANDS lanes for an adder tree. A vector closes on its last lane or
// on a word flagged in_last; unused lanes are zero and out_count reports how
// many lanes are real.
//   clk    : clock, all state changes on its rising edge
//   rst_n  : synchronous active-low reset
//   bus    : operand_packer_if.slave (input word stream, output vector)
// A completed vector goes straight to the output register when the slot is
// free; otherwise it waits in the fill buffer (HOLD, in_ready=0) until the
// consumer takes the current output.
module operand_packer #(
  parameter int NUM_OPERANDS = 9,
  parameter int DATA_WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  operand_packer_if.slave  bus
);
  localparam int CNT_W = $clog2(NUM_OPERANDS + 1);

  typedef logic [NUM_OPERANDS-1:0][DATA_WIDTH-1:0] vec_t;
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] lane_cnt_reg, lane_cnt_next;
  vec_t             fill_buf_reg, fill_buf_next;
  vec_t             out_ops_reg, out_ops_next;
  logic [CNT_W-1:0] out_cnt_reg, out_cnt_next;
  logic             out_valid_reg, out_valid_next;

  logic             accept;
  logic             completing;
  logic             out_taken;
  logic             slot_free;
  logic [CNT_W-1:0] cnt_plus1;
  vec_t             buf_merged;

  assign accept     = bus.in_valid && (state_reg == FILL);
  // in_last only matters on an accepted word, so it is qualified by accept.
  assign completing = accept &&
                      ((lane_cnt_reg == CNT_W'(NUM_OPERANDS - 1)) || bus.in_last);
  assign out_taken  = out_valid_reg && bus.out_ready;
  assign slot_free  = !out_valid_reg || bus.out_ready;
  assign cnt_plus1  = lane_cnt_reg + CNT_W'(1);

  // Fill buffer with the incoming word dropped into its lane. Lanes past the
  // last word stay zero because the buffer is cleared after every transfer.
  generate
    for (genvar gi = 0; gi < NUM_OPERANDS; gi++) begin : g_lane
      assign buf_merged[gi] = (accept && (lane_cnt_reg == CNT_W'(gi)))
                              ? bus.in_data : fill_buf_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= FILL;
      lane_cnt_reg  <= '0;
      fill_buf_reg  <= '0;
      out_ops_reg   <= '0;
      out_cnt_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lane_cnt_reg  <= lane_cnt_next;
      fill_buf_reg  <= fill_buf_next;
      out_ops_reg   <= out_ops_next;
      out_cnt_reg   <= out_cnt_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    lane_cnt_next  = lane_cnt_reg;
    fill_buf_next  = fill_buf_reg;
    out_ops_next   = out_ops_reg;
    out_cnt_next   = out_cnt_reg;
    out_valid_next = out_valid_reg;

    // Consumer took the current vector; reloaded below if another is ready.
    if (out_taken) begin
      out_valid_next = 1'b0;
    end

    case (state_reg)
      FILL: begin
        if (completing && slot_free) begin
          out_ops_next   = buf_merged;
          out_cnt_next   = cnt_plus1;
          out_valid_next = 1'b1;
          fill_buf_next  = '0;
          lane_cnt_next  = '0;
        end else if (completing) begin
          // Output slot busy: park the finished vector; lane_cnt keeps its size.
          fill_buf_next = buf_merged;
          lane_cnt_next = cnt_plus1;
          state_next    = HOLD;
        end else if (accept) begin
          fill_buf_next = buf_merged;
          lane_cnt_next = cnt_plus1;
        end
      end
      HOLD: begin
        if (out_taken) begin
          out_ops_next   = fill_buf_reg;
          out_cnt_next   = lane_cnt_reg;
          out_valid_next = 1'b1;
          fill_buf_next  = '0;
          lane_cnt_next  = '0;
          state_next     = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  assign bus.in_ready     = (state_reg == FILL);
  assign bus.out_operands = out_ops_reg;
  assign bus.out_count    = out_cnt_reg;
  assign bus.out_valid    = out_valid_reg;
endmodule

// File: tb/tb_operand_packer.sv
module tb_operand_packer;
  localparam int N = 9;
  localparam int W = 8;

  typedef logic [N-1:0][W-1:0] vec_t;
  typedef struct {
    vec_t ops;
    int   cnt;
    int   sum;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_packer_if #(.NUM_OPERANDS(N), .DATA_WIDTH(W)) bus ();

  operand_packer #(.NUM_OPERANDS(N), .DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   stalls = 0;
  exp_t sb[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk_vec(input int start, input int n);
    vec_t v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = W'(start + i);
    return v;
  endfunction

  task automatic expect_vec(input int start, input int n, input int sum);
    exp_t e;
    e.ops = mk_vec(start, n);
    e.cnt = n;
    e.sum = sum;
    sb.push_back(e);
    $display("expect: lanes from %0d, count %0d, sum %0d", start, n, sum);
  endtask

  // Offer one word and return #1 after the edge that accepts it.
  task automatic send(input int d, input bit last);
    bit acc;
    bus.in_data  = W'(d);
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    for (int c = 0; c < 200; c++) begin
      acc = bus.in_ready;
      if (!acc) stalls++;
      @(posedge clk);
      #1;
      if (acc) begin
        bus.in_valid = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: word %0d not accepted within 200 cycles", d);
    bus.in_valid = 1'b0;
  endtask

  // Idle cycle with junk on data/last to show they are ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'hEE;
      bus.in_last  = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_last = 1'b0;
  endtask

  // Monitor: pops expected vector on each output handshake, checks stability on stall.
  bit   prev_stall = 1'b0;
  vec_t prev_ops;
  int   prev_cnt;
  always @(negedge clk) begin
    int s;
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_vector: got count %0d lanes %0h, none expected",
                 bus.out_count, bus.out_operands);
      end else begin
        e = sb.pop_front();
        s = 0;
        for (int i = 0; i < N; i++) s += int'(bus.out_operands[i]);
        $display("vector: count %0d lanes %0h sum %0d", bus.out_count, bus.out_operands, s);
        chk("vec_lanes", 128'(bus.out_operands), 128'(e.ops));
        chk("vec_count", 128'(bus.out_count), 128'(e.cnt));
        chk("tree_sum", 128'(s), 128'(e.sum));
      end
    end
    if (rst_n && bus.out_valid && !bus.out_ready) begin
      if (prev_stall) begin
        chk("stall_lanes", 128'(bus.out_operands), 128'(prev_ops));
        chk("stall_count", 128'(bus.out_count), 128'(prev_cnt));
      end
      prev_stall = 1'b1;
      prev_ops   = bus.out_operands;
      prev_cnt   = int'(bus.out_count);
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_count", 128'(bus.out_count), 128'(0));
    chk("rst_out_lanes", 128'(bus.out_operands), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));

    // Full vector 0..8 back-to-back, out_valid right after word 8.
    expect_vec(0, 9, 36);
    for (int i = 0; i < 9; i++) begin
      send(i, 1'b0);
      if (i < 8) chk("early_out_valid", 128'(bus.out_valid), 128'(0));
    end
    chk("latency_out_valid", 128'(bus.out_valid), 128'(1));
    idle(2);

    // Early close with in_last, then a fresh vector starts at lane 0.
    expect_vec(5, 3, 18);
    send(5, 1'b0);
    send(6, 1'b0);
    send(7, 1'b1);
    expect_vec(40, 9, 396);
    for (int i = 0; i < 9; i++) send(40 + i, 1'b0);
    idle(2);

    // Backpressure: 18 words with out_ready=0 -> vec1 held, vec2 in HOLD.
    bus.out_ready = 1'b0;
    expect_vec(0, 9, 36);
    expect_vec(9, 9, 117);
    for (int i = 0; i < 18; i++) send(i, 1'b0);
    chk("hold_in_ready", 128'(bus.in_ready), 128'(0));
    chk("hold_out_valid", 128'(bus.out_valid), 128'(1));
    chk("hold_out_lanes", 128'(bus.out_operands), 128'(mk_vec(0, 9)));
    idle(3);
    chk("hold_in_ready_still", 128'(bus.in_ready), 128'(0));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("xfer_out_valid", 128'(bus.out_valid), 128'(1));
    chk("xfer_in_ready", 128'(bus.in_ready), 128'(1));
    chk("xfer_out_count", 128'(bus.out_count), 128'(9));
    chk("xfer_out_lanes", 128'(bus.out_operands), 128'(mk_vec(9, 9)));
    idle(2);
    bus.out_ready = 1'b1;
    idle(2);

    // Reset mid-vector discards the partial vector; in_valid ignored in reset.
    for (int i = 0; i < 4; i++) send(60 + i, 1'b0);
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd99;
    bus.in_last  = 1'b1;
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("midrst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("midrst_out_count", 128'(bus.out_count), 128'(0));
    chk("midrst_in_ready", 128'(bus.in_ready), 128'(1));
    expect_vec(20, 9, 216);
    for (int i = 0; i < 9; i++) send(20 + i, 1'b0);
    idle(2);

    // in_valid toggling every other cycle: one vector 1..9, no extra pulse.
    expect_vec(1, 9, 45);
    for (int i = 0; i < 9; i++) begin
      send(1 + i, 1'b0);
      idle(1);
    end
    idle(2);

    // Continuous 27-word stream: three vectors, in_ready never drops.
    stalls = 0;
    expect_vec(100, 9, 936);
    expect_vec(109, 9, 1017);
    expect_vec(118, 9, 1098);
    for (int i = 0; i < 27; i++) begin
      send(100 + i, 1'b0);
      chk("stream_in_ready", 128'(bus.in_ready), 128'(1));
    end
    chk("stream_stalls", 128'(stalls), 128'(0));
    idle(4);

    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
